// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared command codes and FSM state encodings for the PC sequencer.
package pc_seq_pkg;
    typedef enum logic [1:0] {
        CMD_INC      = 2'b00,
        CMD_LOAD     = 2'b01,
        CMD_LOAD_INC = 2'b10,
        CMD_REL      = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INC  = 3'd1,
        S_LOAD = 3'd2,
        S_REL  = 3'd3,
        S_FIX  = 3'd4
    } state_t;
endpackage

// File: rtl/pc_seq_page_counter.sv
// pc_seq_page_counter: saturating 8-bit count of PCL carry-outs during PC increments.
module pc_seq_page_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_en,
    input  logic       inc,
    output logic [7:0] count
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count <= 8'd0;
        else if (clk_en && inc && count != 8'hff) count <= count + 8'd1;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: drives PCL/PCH select and increment controls from decoder commands.
// Optional page-cross counter built when PC_SEQ_PAGE_CNT_EN is defined.
module pc_sequencer
    import pc_seq_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_clk_en,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [1:0] i_cmd,
    input  logic [1:0] i_count,
    input  logic       i_rel_fix,
    input  logic       i_pclc,
    output logic       o_pcl_pcl,
    output logic       o_adl_pcl,
    output logic       o_pch_pch,
    output logic       o_adh_pch,
    output logic       o_i_pc,
    output logic       o_done
`ifdef PC_SEQ_PAGE_CNT_EN
    ,
    output logic [7:0] o_page_cnt
`endif
);
    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_inc_q, load_inc_d;
    logic       xfer;

    assign o_done = state_q == S_LOAD || state_q == S_FIX ||
                    (state_q == S_INC && cnt_q == 3'd1) ||
                    (state_q == S_REL && !i_rel_fix);
    assign o_cmd_ready = state_q == S_IDLE || o_done;
    assign xfer = i_clk_en & i_cmd_valid & o_cmd_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_inc_d = load_inc_q;
        if (xfer) begin
            state_d    = cmd_t'(i_cmd) == CMD_INC ? S_INC : cmd_t'(i_cmd) == CMD_REL ? S_REL : S_LOAD;
            // count 0 encodes 4: the zero flag becomes bit 2
            cnt_d      = {i_count == 2'd0, i_count};
            load_inc_d = cmd_t'(i_cmd) == CMD_LOAD_INC;
        end else if (i_clk_en) begin
            state_d = (state_q == S_REL && i_rel_fix) ? S_FIX : (o_done ? S_IDLE : state_q);
            cnt_d   = state_q == S_INC ? cnt_q - 3'd1 : cnt_q;
        end
    end

    // controls are registered from the next state so they are glitch-free Moore outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            load_inc_q <= 1'b0;
            o_pcl_pcl  <= 1'b1;
            o_adl_pcl  <= 1'b0;
            o_pch_pch  <= 1'b1;
            o_adh_pch  <= 1'b0;
            o_i_pc     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            load_inc_q <= load_inc_d;
            o_pcl_pcl  <= state_d inside {S_IDLE, S_INC, S_FIX};
            o_adl_pcl  <= state_d inside {S_LOAD, S_REL};
            o_pch_pch  <= state_d inside {S_IDLE, S_INC, S_REL};
            o_adh_pch  <= state_d inside {S_LOAD, S_FIX};
            o_i_pc     <= state_d == S_INC || (state_d == S_LOAD && load_inc_d);
        end
    end

`ifdef PC_SEQ_PAGE_CNT_EN
    pc_seq_page_counter u_page_cnt (
        .clk    (i_clk),
        .reset_n(i_reset_n),
        .clk_en (i_clk_en),
        .inc    (o_i_pc & i_pclc),
        .count  (o_page_cnt)
    );
`else
    logic unused_pclc;
    assign unused_pclc = i_pclc;
`endif
endmodule
